hazard_detector: RTL and testbench
==================================

HAZARD_DETECTOR -- requirements
Module: hazard_detector

Interface
REQ-001 SHALL have parameter MDU_LAT, default 4, meaning multiply/divide unit occupancy in cycles (legal 2..15).
REQ-002 SHALL have ports `clk` (in, 1, sole clock) and `rst` (in, 1, reset); one clock, asynchronous active-high reset.
REQ-003 SHALL have `id_valid` (in, 1): decode stage holds a valid instruction.
REQ-004 SHALL have `id_rs1`, `id_rs2`, `id_rd` (in, 5 each): decode source/destination registers.
REQ-005 SHALL have `id_wr`, `id_is_load`, `id_is_branch`, `id_pred_taken`, `id_uses_mdu` (in, 1 each): decode attributes.
REQ-006 SHALL have `ex_br_resolved`, `ex_br_taken` (in, 1 each): a branch resolves in EX this cycle, with its actual direction.
REQ-007 SHALL have `pc_freeze`, `do_flush` (in, 1 each): commands returned by the hazard resolver FSM.
REQ-008 SHALL have `data`, `str`, `ctrl`, `branch`, `fwrd`, `crct` (out, 1 each, registered): hazard flags consumed by the resolver.
REQ-009 SHALL have `stall_cnt` (out, 8): count of frozen cycles.

Function
REQ-010 SHALL define issue = id_valid & !pc_freeze & !do_flush.
REQ-011 SHALL keep a 3-stage scoreboard EX/MEM/WB; each entry holds {valid, rd, wr, is_load}.
REQ-012 Scoreboard update each clock: EX <= issue ? ID fields : bubble; MEM <= EX; WB <= MEM.
REQ-013 On do_flush=1: EX <= bubble and MEM <= bubble; WB <= MEM as usual.
REQ-014 A match SHALL require entry valid, wr=1, rd!=0, and rd equal to id_rs1 or id_rs2.
REQ-015 `data` SHALL register (id_valid & any match in EX, MEM or WB).
REQ-016 `fwrd` SHALL register 1 when data would be 1 and no matching EX entry has is_load=1; otherwise 0.
REQ-017 SHALL keep a 4-bit MDU busy counter; issue & id_uses_mdu loads MDU_LAT-1; otherwise it decrements and saturates at 0.
REQ-018 `str` SHALL register (id_valid & id_uses_mdu & counter!=0).
REQ-019 SHALL keep br_pend and br_pred registers; issue & id_is_branch sets br_pend=1 and br_pred=id_pred_taken.
REQ-020 `ctrl` SHALL register br_pend (the pre-update value).
REQ-021 On ex_br_resolved=1 with br_pend=1: branch=1 for exactly one cycle; crct=(ex_br_taken==br_pred); br_pend cleared.
REQ-022 On ex_br_resolved=1 with br_pend=0: the resolution SHALL be ignored and branch=0.
REQ-023 `branch` and `crct` SHALL be 0 in every cycle not covered by REQ-021.
REQ-024 Resolution and a new branch issue in the same cycle: report the old branch per REQ-021; br_pend then reloads from the new branch.
REQ-025 do_flush=1 SHALL clear br_pend unless a new branch issue sets it (none can, per REQ-010).
REQ-026 All flag outputs SHALL have latency 1 cycle from the inputs sampled.
REQ-027 `stall_cnt` SHALL increment on each cycle with pc_freeze=1 and saturate at 255.
REQ-028 The MDU counter SHALL be unaffected by do_flush.

Reset
REQ-029 On rst=1, asynchronously: all scoreboard entries invalid, MDU counter=0, br_pend=0, br_pred=0, stall_cnt=0.
REQ-030 On rst=1, all outputs SHALL be 0 immediately.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight state; the first post-reset cycle behaves as an empty pipeline.

Configuration
REQ-032 Macro HAZ_WB_WRITETHRU_EN: when defined, the WB entry SHALL be excluded from match (the register file writes through); when undefined, WB participates per REQ-014.

Verification
REQ-033 Bench: issue `add` x5; next cycle decode `sub` rs1=x5 -> data=1, fwrd=1 one cycle later.
REQ-034 Bench: issue `load` x7; next cycle decode rs2=x7 -> data=1, fwrd=0; with rd=x0 instead -> data=0.
REQ-035 Bench: MDU_LAT=4; issue MDU op, then present MDU ops for 3 cycles -> str=1 in each; fourth cycle -> str=0.
REQ-036 Bench: issue branch pred=1; resolve with taken=0 -> branch=1, crct=0 for one cycle; ctrl=0 after; then do_flush=1 -> EX/MEM cleared, data=0 on a follow-up rs match.
REQ-037 Bench: hold pc_freeze=1 for 300 cycles -> stall_cnt=255; assert rst mid-run -> all outputs 0 with no clock edge.
REQ-038 Bench: match only in WB -> data=1 without HAZ_WB_WRITETHRU_EN, data=0 with it defined.

Source files
------------

// File: rtl/hazard_detector.sv
// Pipeline hazard flag generator: scoreboard, MDU busy, branch tracking, stall count.
// Optional HAZ_WB_WRITETHRU_EN: WB stage excluded from operand matching.
module hazard_detector #(
  parameter int MDU_LAT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] id_rd,
  input  logic       id_wr,
  input  logic       id_is_load,
  input  logic       id_is_branch,
  input  logic       id_pred_taken,
  input  logic       id_uses_mdu,
  input  logic       ex_br_resolved,
  input  logic       ex_br_taken,
  input  logic       pc_freeze,
  input  logic       do_flush,
  output logic       data,
  output logic       str,
  output logic       ctrl,
  output logic       branch,
  output logic       fwrd,
  output logic       crct,
  output logic [7:0] stall_cnt
);

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
  } sb_t;

  localparam logic [3:0] MDU_LOAD = 4'(MDU_LAT - 1);

  sb_t        ex_q, mem_q, wb_q, id_e;
  logic [3:0] mdu_cnt;
  logic       br_pend, br_pred;
  logic       issue;
  logic       ex_hit, mem_hit, any_hit;
  logic       br_done;

  function automatic logic hit(sb_t e, logic [4:0] r1, logic [4:0] r2);
    return e.v & e.wr & (e.rd != 5'd0) & ((e.rd == r1) | (e.rd == r2));
  endfunction

  assign issue   = id_valid & ~pc_freeze & ~do_flush;
  assign id_e    = '{v: 1'b1, rd: id_rd, wr: id_wr, ld: id_is_load};
  assign ex_hit  = hit(ex_q, id_rs1, id_rs2);
  assign mem_hit = hit(mem_q, id_rs1, id_rs2);
  assign br_done = ex_br_resolved & br_pend;

`ifdef HAZ_WB_WRITETHRU_EN
  // Register file writes through, so WB results are already visible.
  assign any_hit = ex_hit | mem_hit;
`else
  assign any_hit = ex_hit | mem_hit | hit(wb_q, id_rs1, id_rs2);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      mdu_cnt   <= '0;
      br_pend   <= 1'b0;
      br_pred   <= 1'b0;
      stall_cnt <= '0;
      data      <= 1'b0;
      fwrd      <= 1'b0;
      str       <= 1'b0;
      ctrl      <= 1'b0;
      branch    <= 1'b0;
      crct      <= 1'b0;
    end else begin
      ex_q  <= issue ? id_e : '0;
      mem_q <= do_flush ? '0 : ex_q;
      wb_q  <= mem_q;

      if (issue & id_uses_mdu) begin
        mdu_cnt <= MDU_LOAD;
      end else if (mdu_cnt != 4'd0) begin
        mdu_cnt <= mdu_cnt - 4'd1;
      end

      if (issue & id_is_branch) begin
        br_pend <= 1'b1;
        br_pred <= id_pred_taken;
      end else if (br_done | do_flush) begin
        br_pend <= 1'b0;
      end

      if (pc_freeze & (stall_cnt != 8'hff)) begin
        stall_cnt <= stall_cnt + 8'd1;
      end

      data   <= id_valid & any_hit;
      // A load still in EX cannot forward yet.
      fwrd   <= id_valid & any_hit & ~(ex_hit & ex_q.ld);
      str    <= id_valid & id_uses_mdu & (mdu_cnt != 4'd0);
      ctrl   <= br_pend;
      branch <= br_done;
      crct   <= br_done & (ex_br_taken == br_pred);
    end
  end

endmodule

// File: tb/tb_hazard_detector.sv
// Self-checking bench for hazard_detector: directed steps plus random traffic
// against a history-based reference model.
module tb_hazard_detector;

  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_wr, id_is_load, id_is_branch;
  logic       id_pred_taken, id_uses_mdu;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       ex_br_resolved, ex_br_taken, pc_freeze, do_flush;
  logic       data, str, ctrl, branch, fwrd, crct;
  logic [7:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  hazard_detector #(.MDU_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_wr(id_wr), .id_is_load(id_is_load), .id_is_branch(id_is_branch),
    .id_pred_taken(id_pred_taken), .id_uses_mdu(id_uses_mdu),
    .ex_br_resolved(ex_br_resolved), .ex_br_taken(ex_br_taken),
    .pc_freeze(pc_freeze), .do_flush(do_flush),
    .data(data), .str(str), .ctrl(ctrl), .branch(branch),
    .fwrd(fwrd), .crct(crct), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference: the last three issued instructions (youngest first).
  typedef struct {
    bit       v;
    bit [4:0] rd;
    bit       w;
    bit       ld;
  } ent_t;

  ent_t hist[3];
  int   m_mdu, m_stall;
  bit   m_pend, m_pred;

  task automatic chk(string tag, int got, int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) hist[i] = '{0, 0, 0, 0};
    m_mdu = 0; m_stall = 0; m_pend = 0; m_pred = 0;
  endtask

  function automatic bit hits(int i);
    return hist[i].v && hist[i].w && hist[i].rd != 0 &&
           (hist[i].rd == id_rs1 || hist[i].rd == id_rs2);
  endfunction

  task automatic step();
    bit iss, e_data, e_fwrd, e_str, e_ctrl, e_br, e_crct, any;
    int nwb;
`ifdef HAZ_WB_WRITETHRU_EN
    nwb = 2;
`else
    nwb = 3;
`endif
    iss = id_valid && !pc_freeze && !do_flush;
    any = 0;
    for (int i = 0; i < nwb; i++) if (hits(i)) any = 1;
    e_data = id_valid && any;
    e_fwrd = e_data && !(hits(0) && hist[0].ld);
    e_str  = id_valid && id_uses_mdu && m_mdu != 0;
    e_ctrl = m_pend;
    e_br   = ex_br_resolved && m_pend;
    e_crct = e_br && (ex_br_taken == m_pred);
    @(posedge clk);
    #1;
    // next model state
    hist[2] = hist[1];
    hist[1] = do_flush ? '{0, 0, 0, 0} : hist[0];
    hist[0] = iss ? '{1, id_rd, id_wr, id_is_load} : '{0, 0, 0, 0};
    if (iss && id_uses_mdu) m_mdu = LAT - 1;
    else if (m_mdu > 0) m_mdu--;
    if (iss && id_is_branch) begin
      m_pend = 1; m_pred = id_pred_taken;
    end else if (e_br || do_flush) m_pend = 0;
    if (pc_freeze && m_stall < 255) m_stall++;
    chk("data", data, e_data);
    chk("fwrd", fwrd, e_fwrd);
    chk("str", str, e_str);
    chk("ctrl", ctrl, e_ctrl);
    chk("branch", branch, e_br);
    chk("crct", crct, e_crct);
    chk("stall_cnt", stall_cnt, m_stall);
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_wr = 0;
    id_is_load = 0; id_is_branch = 0; id_pred_taken = 0; id_uses_mdu = 0;
    ex_br_resolved = 0; ex_br_taken = 0; pc_freeze = 0; do_flush = 0;
  endtask

  task automatic dec(input bit [4:0] rs1, input bit [4:0] rs2,
                     input bit [4:0] rd, input bit wr, input bit ld);
    idle();
    id_valid = 1; id_rs1 = rs1; id_rs2 = rs2;
    id_rd = rd; id_wr = wr; id_is_load = ld;
  endtask

  task automatic drain();
    idle();
    repeat (4) step();
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_data"}, data, 0);
    chk({tag, "_str"}, str, 0);
    chk({tag, "_ctrl"}, ctrl, 0);
    chk({tag, "_branch"}, branch, 0);
    chk({tag, "_fwrd"}, fwrd, 0);
    chk({tag, "_crct"}, crct, 0);
    chk({tag, "_stall"}, stall_cnt, 0);
  endtask

  initial begin
    idle();
    model_reset();
    rst = 1;
    #1;
    chk_all_zero("rst0");
    @(negedge clk);
    rst = 0;
    drain();

    // ALU producer then dependent consumer: forwardable
    dec(0, 0, 5, 1, 0); step();
    dec(5, 0, 0, 0, 0); step();
    chk("add_sub_data", data, 1);
    chk("add_sub_fwrd", fwrd, 1);
    drain();

    // Load producer in EX: hazard, no forwarding
    dec(0, 0, 7, 1, 1); step();
    dec(0, 7, 0, 0, 0); step();
    chk("load_data", data, 1);
    chk("load_fwrd", fwrd, 0);
    drain();
    dec(0, 0, 0, 1, 1); step();
    dec(0, 0, 0, 0, 0); step();
    chk("x0_data", data, 0);
    drain();

    // MDU occupancy
    dec(0, 0, 0, 0, 0); id_uses_mdu = 1; step();
    for (int i = 0; i < 3; i++) begin
      dec(0, 0, 0, 0, 0); id_uses_mdu = 1; pc_freeze = 1; step();
      chk("mdu_busy", str, 1);
    end
    dec(0, 0, 0, 0, 0); id_uses_mdu = 1; pc_freeze = 1; step();
    chk("mdu_free", str, 0);
    drain();

    // Mispredicted branch, then flush
    dec(0, 0, 0, 0, 0); id_is_branch = 1; id_pred_taken = 1; step();
    idle(); ex_br_resolved = 1; ex_br_taken = 0; step();
    chk("br_branch", branch, 1);
    chk("br_crct", crct, 0);
    chk("br_ctrl", ctrl, 1);
    idle(); step();
    chk("br_branch_clr", branch, 0);
    chk("br_ctrl_clr", ctrl, 0);
    dec(0, 0, 9, 1, 0); step();
    dec(9, 0, 0, 0, 0); do_flush = 1; step();
    chk("flush_data_ex", data, 1);
    dec(9, 0, 0, 0, 0); step();
    chk("flush_follow", data, 0);
    drain();

    // Producer only in WB
    dec(0, 0, 11, 1, 0); step();
    idle(); step();
    idle(); step();
    dec(0, 11, 0, 0, 0); step();
`ifdef HAZ_WB_WRITETHRU_EN
    chk("wb_only", data, 0);
`else
    chk("wb_only", data, 1);
`endif
    drain();

    // Random traffic
    for (int n = 0; n < 500; n++) begin
      id_valid       = ($urandom_range(0, 3) != 0);
      id_rs1         = 5'($urandom_range(0, 7));
      id_rs2         = 5'($urandom_range(0, 7));
      id_rd          = 5'($urandom_range(0, 7));
      id_wr          = 1'($urandom);
      id_is_load     = 1'($urandom);
      id_is_branch   = ($urandom_range(0, 5) == 0);
      id_pred_taken  = 1'($urandom);
      id_uses_mdu    = ($urandom_range(0, 4) == 0);
      ex_br_resolved = ($urandom_range(0, 3) == 0);
      ex_br_taken    = 1'($urandom);
      pc_freeze      = ($urandom_range(0, 4) == 0);
      do_flush       = ($urandom_range(0, 9) == 0);
      step();
    end

    // Stall counter saturation
    idle(); pc_freeze = 1;
    repeat (300) step();
    chk("stall_sat", stall_cnt, 255);

    // Asynchronous reset between clock edges
    dec(0, 0, 3, 1, 0); id_is_branch = 1; id_uses_mdu = 1; step();
    dec(3, 0, 0, 0, 0); step();
    #2;
    rst = 1;
    #1;
    chk_all_zero("rst_mid");
    model_reset();
    @(negedge clk);
    rst = 0;
    dec(3, 3, 0, 0, 0); id_uses_mdu = 1; step();
    chk("post_rst_data", data, 0);
    chk("post_rst_str", str, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
